latch_chain_config_loader: RTL and testbench

- Writer side of the two-phase latch configuration shift chain used by the fabric's LUT and routing BELs.
- Accepts configuration words over a valid/ready stream and serialises them MSB-first onto the chain head (CONF_DATA).
- Generates non-overlapping enables: PHI_A for even latches, PHI_B for odd latches. Holds MODE high for the whole load.
- Sits between the bitstream source (UART/frame controller) and the chain input of a tile column.

---
 rtl/latch_chain_config_loader.sv | 157 +++++++++++++++
 tb/tb_latch_chain_config_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_chain_config_loader.sv
// Writer side of the two-phase latch configuration chain: serialises words MSB-first with non-overlapping PHI_A/PHI_B.
// Define LATCH_LOADER_READBACK_EN to compute a CRC-16-CCITT of CONF_TAIL on RB_CRC; otherwise RB_CRC is 0.
module latch_chain_config_loader #(
   parameter int WORD_W  = 32,
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [WORD_W-1:0] WORD_DATA,
   input  logic              WORD_VALID,
   input  logic              WORD_LAST,
   output logic              WORD_READY,
   input  logic              ABORT,
   output logic              CONF_DATA,
   output logic              PHI_A,
   output logic              PHI_B,
   output logic              MODE,
   output logic              BUSY,
   output logic              DONE,
   input  logic              CONF_TAIL,
   output logic [15:0]       RB_CRC
);
   localparam int MAX_LEN = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);
   localparam int BIT_W   = $clog2(WORD_W);

   typedef enum logic [2:0] {IDLE, SETUP, PHA, MID, PHB, TAIL, WAIT, FINISH} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  ph_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] shift_reg;
   logic              last_word;
   logic              abort_flag;
   logic              rst_hold;
   logic              abort_now;
   logic              gap_end;
   logic              pulse_end;
   logic              load;
   logic              shift;

   assign abort_now = abort_flag | ABORT;
   assign gap_end   = (ph_cnt == CNT_W'(GAP_W - 1));
   assign pulse_end = (ph_cnt == CNT_W'(PULSE_W - 1));

   always_comb begin
      state_nxt  = state;
      WORD_READY = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
      case (state)
         IDLE: begin
            // rst_hold keeps READY low on the first cycle after reset
            WORD_READY = ~rst_hold;
            if (WORD_VALID && !rst_hold) begin
               load      = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP:  if (gap_end)   state_nxt = PHA;
         PHA:    if (pulse_end) state_nxt = MID;
         MID:    if (gap_end)   state_nxt = PHB;
         PHB: begin
            if (pulse_end) begin
               if (abort_now)
                  state_nxt = IDLE;
               else if (bit_cnt == '0)
                  state_nxt = TAIL;
               else begin
                  shift     = 1'b1;
                  state_nxt = SETUP;
               end
            end
         end
         TAIL:   if (gap_end) state_nxt = last_word ? FINISH : WAIT;
         WAIT: begin
            // a pending abort blocks the handshake in the same cycle
            WORD_READY = ~abort_now;
            if (abort_now)
               state_nxt = IDLE;
            else if (WORD_VALID) begin
               load      = 1'b1;
               state_nxt = SETUP;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         ph_cnt     <= '0;
         bit_cnt    <= '0;
         abort_flag <= 1'b0;
         rst_hold   <= 1'b1;
      end else begin
         state    <= state_nxt;
         rst_hold <= 1'b0;
         if (state_nxt != state)
            ph_cnt <= '0;
         else
            ph_cnt <= ph_cnt + CNT_W'(1);
         if (load)
            bit_cnt <= BIT_W'(WORD_W - 1);
         else if (shift)
            bit_cnt <= bit_cnt - BIT_W'(1);
         if (state == IDLE || state_nxt == IDLE)
            abort_flag <= 1'b0;
         else
            abort_flag <= abort_now;
      end
   end

   // word datapath: loaded on handshake, shifted at each bit boundary
   always_ff @(posedge CLK) begin
      if (load) begin
         shift_reg <= WORD_DATA;
         last_word <= WORD_LAST;
      end else if (shift) begin
         shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      end
   end

   assign MODE      = (state != IDLE) && (state != FINISH);
   assign BUSY      = (state != IDLE);
   assign PHI_A     = (state == PHA);
   assign PHI_B     = (state == PHB);
   assign DONE      = (state == FINISH);
   assign CONF_DATA = MODE & shift_reg[WORD_W-1];

`ifdef LATCH_LOADER_READBACK_EN
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);
   endfunction

   logic [15:0] crc;

   always_ff @(posedge CLK) begin
      if (RESET)
         crc <= '0;
      else if (state == IDLE && load)
         crc <= 16'hFFFF;
      else if (state == PHB && pulse_end)
         crc <= crc16_step(crc, CONF_TAIL);
   end

   assign RB_CRC = crc;
`else
   logic unused_tail;
   assign unused_tail = CONF_TAIL;
   assign RB_CRC      = 16'h0000;
`endif

endmodule

// File: tb/tb_latch_chain_config_loader.sv
// Scoreboard bench for latch_chain_config_loader: default-timing instance plus a PULSE_W=3/GAP_W=2 instance.
module tb_latch_chain_config_loader;
   localparam int WW = 32;
   localparam int PW = 2;
   localparam int GW = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] word_data = '0;
   logic        word_valid = 1'b0;
   logic        word_last = 1'b0;
   logic        abort = 1'b0;
   logic        conf_tail = 1'b0;
   logic        word_ready, conf_data, phi_a, phi_b, mode, busy, done;
   logic [15:0] rb_crc;

   logic        reset2 = 1'b1;
   logic [7:0]  word_data2 = '0;
   logic        word_valid2 = 1'b0;
   logic        word_ready2, conf_data2, phi_a2, phi_b2, mode2, busy2, done2;
   logic [15:0] rb_crc2;

   int total = 0;
   int bad = 0;
   int edge_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   latch_chain_config_loader #(.WORD_W(WW), .PULSE_W(PW), .GAP_W(GW)) u_dut (
      .CLK(clk), .RESET(reset), .WORD_DATA(word_data), .WORD_VALID(word_valid),
      .WORD_LAST(word_last), .WORD_READY(word_ready), .ABORT(abort),
      .CONF_DATA(conf_data), .PHI_A(phi_a), .PHI_B(phi_b), .MODE(mode),
      .BUSY(busy), .DONE(done), .CONF_TAIL(conf_tail), .RB_CRC(rb_crc));

   latch_chain_config_loader #(.WORD_W(8), .PULSE_W(3), .GAP_W(2)) u_dut2 (
      .CLK(clk), .RESET(reset2), .WORD_DATA(word_data2), .WORD_VALID(word_valid2),
      .WORD_LAST(1'b1), .WORD_READY(word_ready2), .ABORT(1'b0),
      .CONF_DATA(conf_data2), .PHI_A(phi_a2), .PHI_B(phi_b2), .MODE(mode2),
      .BUSY(busy2), .DONE(done2), .CONF_TAIL(1'b0), .RB_CRC(rb_crc2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // CRC-16-CCITT over a run of zero tail bits from seed 0xFFFF
   function automatic logic [15:0] crc_zeros(input int nbits);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < nbits; i++)
         c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      return c;
   endfunction

   logic [15:0] exp_crc;
`ifdef LATCH_LOADER_READBACK_EN
   initial exp_crc = crc_zeros(32);
`else
   initial exp_crc = 16'h0000;
`endif

   // scoreboard for the default instance
   bit   exp_bits[$];
   int   exp_len[$];
   logic pa_d = 0, pb_d = 0, busy_d = 0, cur_bit = 0;
   int   a_lo = 100, b_lo = 100, wa = 0, wb = 0, frame_bits = 0;
   bit   rst_cut = 0;

   always @(negedge clk) begin
      if (busy && !busy_d) frame_bits = 0;
      if (phi_a && !pa_d) begin
         chk("a_gap", (b_lo >= GW) && !phi_b, 1);
         if (exp_bits.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_bit: got bit %0b with none expected", conf_data);
         end else
            chk("conf_bit", conf_data, exp_bits.pop_front());
         cur_bit = conf_data;
         frame_bits++;
      end
      if (phi_b && !pb_d) chk("b_gap", (a_lo >= GW) && !phi_a, 1);
      if (phi_a || phi_b) chk("data_stable", conf_data, cur_bit);
      if (!phi_a && pa_d) chk("a_width", wa, PW);
      if (!phi_b && pb_d) begin
         if (rst_cut) rst_cut = 0;
         else chk("b_width", wb, PW);
      end
      if (done) begin
         chk("done_mode", mode, 0);
         if (exp_len.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_done: got DONE with no frame expected");
         end else
            chk("frame_bits", frame_bits, exp_len.pop_front());
      end
      wa = phi_a ? wa + 1 : 0;
      wb = phi_b ? wb + 1 : 0;
      a_lo = phi_a ? 0 : (a_lo < 100 ? a_lo + 1 : a_lo);
      b_lo = phi_b ? 0 : (b_lo < 100 ? b_lo + 1 : b_lo);
      pa_d = phi_a; pb_d = phi_b; busy_d = busy;
   end

   // scoreboard for the PULSE_W=3, GAP_W=2 instance
   bit   exp2[$];
   logic pa2_d = 0, pb2_d = 0, cd2_d = 0, cur2 = 0;
   int   a2_lo = 100, b2_lo = 100, wa2 = 0, wb2 = 0, last_rise = -1;

   always @(negedge clk) begin
      if (phi_a2 && !pa2_d) begin
         if (last_rise >= 0) chk("d2_period", edge_n - last_rise, 10);
         chk("d2_a_gap", (b2_lo >= 2) && !phi_b2, 1);
         if (exp2.size() == 0) begin
            total++; bad++;
            $display("FAIL d2_extra_bit: got bit %0b with none expected", conf_data2);
         end else
            chk("d2_bit", conf_data2, exp2.pop_front());
         last_rise = edge_n;
         cur2 = conf_data2;
      end
      if (phi_b2 && !pb2_d) chk("d2_b_gap", (a2_lo >= 2) && !phi_a2, 1);
      if (phi_a2 || phi_b2) chk("d2_stable", conf_data2, cur2);
      if (conf_data2 != cd2_d) chk("d2_change_phases_low", {phi_a2, phi_b2}, 0);
      if (!phi_a2 && pa2_d) chk("d2_a_width", wa2, 3);
      if (!phi_b2 && pb2_d) chk("d2_b_width", wb2, 3);
      wa2 = phi_a2 ? wa2 + 1 : 0;
      wb2 = phi_b2 ? wb2 + 1 : 0;
      a2_lo = phi_a2 ? 0 : (a2_lo < 100 ? a2_lo + 1 : a2_lo);
      b2_lo = phi_b2 ? 0 : (b2_lo < 100 ? b2_lo + 1 : b2_lo);
      pa2_d = phi_a2; pb2_d = phi_b2; cd2_d = conf_data2;
   end

   task automatic send(input logic [31:0] d, input logic last, input int npush, output int hs);
      int n;
      n = 0;
      for (int i = 0; i < npush; i++) exp_bits.push_back(d[31-i]);
      @(negedge clk);
      word_data = d; word_last = last; word_valid = 1'b1;
      #1;
      while (!word_ready && n < 1000) begin
         @(negedge clk); #1; n++;
      end
      chk("send_ready", word_ready, 1);
      @(posedge clk); #1;
      hs = edge_n;
      word_valid = 1'b0;
   endtask

   task automatic wait_done(input int hs, input int lat);
      int n, ml;
      n = 0; ml = 0;
      @(negedge clk);
      while (!done && n < 2000) begin
         if (!mode) ml++;
         @(negedge clk); n++;
      end
      chk("done_seen", done, 1);
      chk("done_latency", edge_n - hs, lat);
      chk("mode_held", ml, 0);
   endtask

   task automatic wait_ready(input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (!word_ready && n < limit) begin
         @(negedge clk); n++;
      end
      chk("ready_wait", word_ready, 1);
   endtask

   initial begin
      int hs, na, nb, dn, n;
      logic pa_p, pb_p;
      logic [7:0] w2;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {word_ready, conf_data, phi_a, phi_b, mode, busy, done}, 0);
      chk("rst_crc", rb_crc, 0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", {word_ready, mode, busy}, 3'b100);

      // single word frame
      exp_len.push_back(32);
      send(32'hA500_0001, 1'b1, 32, hs);
      chk("k1_outs", {mode, conf_data, word_ready, busy}, 4'b1101);
      wait_done(hs, 193);
      chk("rb_crc_frame", rb_crc, exp_crc);
      @(negedge clk);
      chk("done_one_cycle", {done, mode, word_ready}, 3'b001);

      // two words with a gap spent in WAIT
      exp_len.push_back(64);
      send(32'h0000_FFFF, 1'b0, 32, hs);
      wait_ready(400);
      chk("wait_entry", {mode, busy, phi_a, phi_b}, 4'b1100);
      repeat (10) @(negedge clk);
      chk("wait_hold", {mode, busy, word_ready, phi_a, phi_b, done}, 6'b111000);
      send(32'h1234_5678, 1'b1, 32, hs);
      wait_done(hs, 193);

      // abort during PHA of bit 5
      send(32'hC300_0000, 1'b1, 6, hs);
      na = 0; pa_p = 0;
      for (int i = 0; i < 200 && na < 6; i++) begin
         @(negedge clk);
         if (phi_a && !pa_p) na++;
         pa_p = phi_a;
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      dn = 0;
      for (int i = 0; i < 50 && busy; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_idle", {busy, mode, done, word_ready}, 4'b0001);
      chk("abort_no_done", dn, 0);
      chk("abort_bits_left", exp_bits.size(), 0);
      exp_len.push_back(32);
      send(32'h0000_0003, 1'b1, 32, hs);
      wait_done(hs, 193);

      // abort together with a handshake in WAIT
      send(32'h0000_0005, 1'b0, 32, hs);
      wait_ready(400);
      word_data = 32'hFFFF_FFFF; word_last = 1'b1; word_valid = 1'b1; abort = 1'b1;
      #1;
      chk("abort_blocks_ready", word_ready, 0);
      @(posedge clk); #1;
      word_valid = 1'b0; abort = 1'b0;
      chk("abort_wait_idle", {busy, mode, done}, 0);
      repeat (3) @(negedge clk);
      chk("abort_word_dropped", busy, 0);

      // reset during PHB of bit 2
      send(32'h6000_0000, 1'b1, 3, hs);
      nb = 0; pb_p = 0;
      for (int i = 0; i < 200 && nb < 3; i++) begin
         @(negedge clk);
         if (phi_b && !pb_p) nb++;
         pb_p = phi_b;
      end
      reset = 1'b1; rst_cut = 1;
      @(posedge clk); #1;
      chk("rst_mid_outs", {word_ready, conf_data, phi_a, phi_b, mode, busy, done}, 0);
      chk("rst_mid_crc", rb_crc, 0);
      @(negedge clk); reset = 1'b0;
      exp_len.push_back(32);
      send(32'hFFFF_FFFF, 1'b1, 32, hs);
      wait_done(hs, 193);
      chk("rb_crc_end", rb_crc, exp_crc);

      // wide-timing instance
      @(negedge clk); reset2 = 1'b0;
      w2 = 8'hB4;
      for (int i = 0; i < 8; i++) exp2.push_back(w2[7-i]);
      @(negedge clk);
      word_data2 = w2; word_valid2 = 1'b1;
      #1;
      chk("d2_ready", word_ready2, 1);
      @(posedge clk); #1;
      hs = edge_n;
      word_valid2 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!done2 && n < 500) begin
         @(negedge clk); n++;
      end
      chk("d2_done_seen", done2, 1);
      chk("d2_done_latency", edge_n - hs, 82);

      @(negedge clk);
      chk("bits_left", exp_bits.size(), 0);
      chk("frames_left", exp_len.size(), 0);
      chk("d2_bits_left", exp2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
